// File: rtl/pio_poll_pkg.sv
// Shared types and constants for the edge-capture PIO poll master.
package pio_poll_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdCap,
        StWtCap,
        StClr,
        StRdLvl,
        StWtLvl,
        StEmit
    } poll_state_e;

    localparam int unsigned PIO_ADDR_DATA     = 0;
    localparam int unsigned PIO_ADDR_EDGE_CAP = 3;

    // Width of the dip-switch PIO this master normally services.
    localparam int unsigned PIO_W = 4;

    typedef struct packed {
        logic [PIO_W-1:0] edges;
        logic [PIO_W-1:0] level;
    } pio_evt_t;

endpackage

// File: rtl/pio_edge_poll_master.sv
// Avalon-MM initiator that polls an edge-capture PIO, clears serviced bits and
// emits each serviced capture as an {edges, level} event on a valid/ready stream.
module pio_edge_poll_master
    import pio_poll_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned POLL_CYCLES  = 1000,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned CAP_ADDR     = PIO_ADDR_EDGE_CAP,
    parameter int unsigned DATA_ADDR    = PIO_ADDR_DATA
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [1:0]       m_address,
    output logic             m_chipselect,
    output logic             m_write_n,
    output logic [31:0]      m_writedata,
    input  logic [31:0]      m_readdata,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_edges,
    output logic [WIDTH-1:0] evt_level,
    output logic [15:0]      evt_count
);

    localparam int unsigned TMR_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_CYCLES - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(READ_LATENCY);
    localparam logic [1:0]       CAP_A      = 2'(CAP_ADDR);
    localparam logic [1:0]       DATA_A     = 2'(DATA_ADDR);

    poll_state_e      state_q;
    logic [TMR_W-1:0] tmr_q;
    logic [LAT_W-1:0] lat_q;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] cap_q;
    logic [1:0]       addr_q;
    logic             cs_q;
    logic             write_n_q;
    logic [31:0]      wdata_q;
    logic             evt_valid_q;
    logic [WIDTH-1:0] evt_edges_q;
    logic [WIDTH-1:0] evt_level_q;
    logic [15:0]      evt_count_q;

    // Only the low WIDTH bits of the slave data are meaningful.
    logic unused_rdata;
    assign unused_rdata = ^m_readdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            tmr_q       <= TMR_RELOAD;
            lat_q       <= '0;
            rdata_q     <= '0;
            cap_q       <= '0;
            addr_q      <= '0;
            cs_q        <= 1'b0;
            write_n_q   <= 1'b1;
            wdata_q     <= '0;
            evt_valid_q <= 1'b0;
            evt_edges_q <= '0;
            evt_level_q <= '0;
            evt_count_q <= '0;
        end else begin
            // Read data is registered on the way in; wait states absorb that cycle.
            rdata_q   <= m_readdata[WIDTH-1:0];
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        if (tmr_q == '0) begin
                            state_q   <= StRdCap;
                            cs_q      <= 1'b1;
                            write_n_q <= 1'b1;
                            addr_q    <= CAP_A;
                        end else begin
                            tmr_q <= tmr_q - TMR_W'(1);
                        end
                    end
                end
                StRdCap: begin
                    state_q <= StWtCap;
                    lat_q   <= LAT_LOAD;
                end
                StWtCap: begin
                    if (lat_q == '0) begin
                        if (rdata_q == '0) begin
                            state_q <= StIdle;
                            tmr_q   <= TMR_RELOAD;
                        end else begin
                            // Clear exactly what was read; later edges survive to the next poll.
                            state_q   <= StClr;
                            cap_q     <= rdata_q;
                            cs_q      <= 1'b1;
                            write_n_q <= 1'b0;
                            addr_q    <= CAP_A;
                            wdata_q   <= 32'(rdata_q);
                        end
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                StClr: begin
                    state_q   <= StRdLvl;
                    cs_q      <= 1'b1;
                    write_n_q <= 1'b1;
                    addr_q    <= DATA_A;
                end
                StRdLvl: begin
                    state_q <= StWtLvl;
                    lat_q   <= LAT_LOAD;
                end
                StWtLvl: begin
                    if (lat_q == '0) begin
                        state_q     <= StEmit;
                        evt_valid_q <= 1'b1;
                        evt_edges_q <= cap_q;
                        evt_level_q <= rdata_q;
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                StEmit: begin
                    if (evt_ready) begin
                        state_q     <= StIdle;
                        tmr_q       <= TMR_RELOAD;
                        evt_valid_q <= 1'b0;
                        evt_count_q <= evt_count_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tmr_q   <= TMR_RELOAD;
                end
            endcase
        end
    end

    assign m_address    = addr_q;
    assign m_chipselect = cs_q;
    assign m_write_n    = write_n_q;
    assign m_writedata  = wdata_q;
    assign evt_valid    = evt_valid_q;
    assign evt_edges    = evt_edges_q;
    assign evt_level    = evt_level_q;
    assign evt_count    = evt_count_q;

endmodule

// File: tb/tb_pio_edge_poll_master.sv
// Directed bench for pio_edge_poll_master against a behavioural edge-capture PIO slave.
module tb_pio_edge_poll_master;
    import pio_poll_pkg::*;

    localparam int unsigned P = 8;
    localparam int unsigned L = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_edges;
    logic [3:0]  evt_level;
    logic [15:0] evt_count;

    always #5 clk = ~clk;

    pio_edge_poll_master #(
        .WIDTH        (4),
        .POLL_CYCLES  (P),
        .READ_LATENCY (L),
        .CAP_ADDR     (PIO_ADDR_EDGE_CAP),
        .DATA_ADDR    (PIO_ADDR_DATA)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_edges    (evt_edges),
        .evt_level    (evt_level),
        .evt_count    (evt_count)
    );

    // Edge-capture PIO slave: any-edge capture, W1C with clear priority, latency-1 reads.
    logic [3:0] in_port;
    logic [3:0] in_prev;
    logic [3:0] cap_reg;
    logic [3:0] clr_mask;

    assign clr_mask = (m_chipselect && !m_write_n && m_address == 2'(PIO_ADDR_EDGE_CAP))
                      ? m_writedata[3:0] : 4'h0;

    always @(posedge clk) begin
        if (reset) begin
            in_prev    <= in_port;
            cap_reg    <= 4'h0;
            m_readdata <= 32'h0;
        end else begin
            in_prev <= in_port;
            cap_reg <= (cap_reg | (in_port ^ in_prev)) & ~clr_mask;
            if (m_chipselect && m_write_n) begin
                if (m_address == 2'(PIO_ADDR_EDGE_CAP))  m_readdata <= {28'h0, cap_reg};
                else if (m_address == 2'(PIO_ADDR_DATA)) m_readdata <= {28'h0, in_port};
                else                                     m_readdata <= 32'h0;
            end
        end
    end

    // Bus monitor
    int          cyc      = 0;
    int          n_cap_rd = 0;
    int          n_wr     = 0;
    int          n_bp     = 0;
    int          rd_last  = 0;
    int          rd_prev  = 0;
    logic [31:0] last_wd  = 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_chipselect && m_write_n && m_address == 2'(PIO_ADDR_EDGE_CAP)) begin
            n_cap_rd <= n_cap_rd + 1;
            rd_prev  <= rd_last;
            rd_last  <= cyc;
        end
        if (m_chipselect && !m_write_n) begin
            n_wr    <= n_wr + 1;
            last_wd <= m_writedata;
        end
        if (m_chipselect && evt_valid) n_bp <= n_bp + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // sel: 0 = event valid, 1 = clear write on the bus, 2 = level read on the bus
    task automatic wait_for(input int sel, input int budget, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((sel == 0 && evt_valid) ||
                (sel == 1 && m_chipselect && !m_write_n) ||
                (sel == 2 && m_chipselect && m_write_n && m_address == 2'(PIO_ADDR_DATA))) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, got no event, expected one", name, budget);
        end
    endtask

    task automatic expect_evt(input string name, input pio_evt_t exp);
        bit ok;
        wait_for(0, 60, name, ok);
        if (ok) begin
            check({name, "_edges"}, 32'(evt_edges), 32'(exp.edges));
            check({name, "_level"}, 32'(evt_level), 32'(exp.level));
        end
    endtask

    typedef struct {
        logic [3:0]  in_val;
        pio_evt_t    evt;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        int nr;
        int nw;
        int bp0;
        int unstable;

        vecs[0] = '{in_val: 4'h4, evt: '{edges: 4'h4, level: 4'h4}, wd: 32'h4};
        vecs[1] = '{in_val: 4'h5, evt: '{edges: 4'h1, level: 4'h5}, wd: 32'h1};
        vecs[2] = '{in_val: 4'hA, evt: '{edges: 4'hF, level: 4'hA}, wd: 32'hF};
        vecs[3] = '{in_val: 4'h2, evt: '{edges: 4'h8, level: 4'h2}, wd: 32'h8};

        reset     = 1'b1;
        enable    = 1'b0;
        evt_ready = 1'b0;
        in_port   = 4'h0;
        step(3);
        check("rst_cs",      32'(m_chipselect), 32'h0);
        check("rst_write_n", 32'(m_write_n),    32'h1);
        check("rst_addr",    32'(m_address),    32'h0);
        check("rst_wdata",   m_writedata,       32'h0);
        check("rst_valid",   32'(evt_valid),    32'h0);
        check("rst_edges",   32'(evt_edges),    32'h0);
        check("rst_level",   32'(evt_level),    32'h0);
        check("rst_count",   32'(evt_count),    32'h0);
        reset = 1'b0;

        // T1: no edges, polls every P+2+L cycles
        enable    = 1'b1;
        evt_ready = 1'b1;
        step(40);
        check("t1_reads_ge3", 32'(n_cap_rd >= 3), 32'h1);
        check("t1_period",    32'(rd_last - rd_prev), 32'(P + 2 + L));
        check("t1_no_writes", 32'(n_wr), 32'h0);
        check("t1_valid",     32'(evt_valid), 32'h0);
        check("t1_count",     32'(evt_count), 32'h0);

        // T2: table of single input changes
        for (int i = 0; i < 4; i++) begin
            in_port = vecs[i].in_val;
            wait_for(0, 60, $sformatf("vec%0d_evt", i), ok);
            if (ok) begin
                check($sformatf("vec%0d_edges", i), 32'(evt_edges), 32'(vecs[i].evt.edges));
                check($sformatf("vec%0d_level", i), 32'(evt_level), 32'(vecs[i].evt.level));
                check($sformatf("vec%0d_wdata", i), last_wd, vecs[i].wd);
                step(1);
                exp_cnt++;
                check($sformatf("vec%0d_count", i), 32'(evt_count), 32'(exp_cnt));
                check($sformatf("vec%0d_drop", i), 32'(evt_valid), 32'h0);
            end
        end
        nw = n_wr;
        nr = n_cap_rd;
        step(25);
        check("t2_idle_no_write", 32'(n_wr), 32'(nw));
        check("t2_idle_polls",    32'(n_cap_rd - nr >= 2), 32'h1);
        check("t2_idle_valid",    32'(evt_valid), 32'h0);

        // T3: backpressure, bit3 toggles while the bit0 event is held
        evt_ready = 1'b0;
        in_port   = 4'h3;
        expect_evt("t3_first", '{edges: 4'h1, level: 4'h3});
        bp0      = n_bp;
        unstable = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 5) in_port = 4'hB;
            step(1);
            if (!evt_valid || evt_edges != 4'h1 || evt_level != 4'h3) unstable++;
        end
        check("t3_stable",     32'(unstable), 32'h0);
        check("t3_no_traffic", 32'(n_bp - bp0), 32'h0);
        check("t3_count_held", 32'(evt_count), 32'(exp_cnt));
        evt_ready = 1'b1;
        step(1);
        exp_cnt++;
        check("t3_count_acc", 32'(evt_count), 32'(exp_cnt));
        expect_evt("t3_second", '{edges: 4'h8, level: 4'hB});
        step(1);
        exp_cnt++;

        // T4: new edge on bit1 lands with the clear of bit1; bit2 edge survives
        in_port = 4'h9;
        wait_for(1, 60, "t4_clr", ok);
        if (ok) begin
            in_port = 4'hF;
            check("t4_wdata", m_writedata, 32'h2);
        end
        expect_evt("t4_first", '{edges: 4'h2, level: 4'hF});
        step(1);
        exp_cnt++;
        expect_evt("t4_second", '{edges: 4'h4, level: 4'hF});
        step(1);
        exp_cnt++;
        check("t4_count", 32'(evt_count), 32'(exp_cnt));
        nw = n_wr;
        step(25);
        check("t4_bit1_lost", 32'(n_wr), 32'(nw));

        // T5a: enable dropped in the level wait; sequence still completes
        in_port = 4'hE;
        wait_for(2, 60, "t5_lvl_rd", ok);
        step(1);
        enable = 1'b0;
        expect_evt("t5_evt", '{edges: 4'h1, level: 4'hE});
        step(1);
        exp_cnt++;
        check("t5_count", 32'(evt_count), 32'(exp_cnt));
        nr = n_cap_rd;
        step(30);
        check("t5_no_poll", 32'(n_cap_rd), 32'(nr));
        enable = 1'b1;
        ok     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (n_cap_rd != nr) begin
                ok = 1'b1;
                break;
            end
        end
        check("t5_resume", 32'(ok), 32'h1);

        // T5b: reset in the clear cycle
        in_port = 4'h6;
        wait_for(1, 60, "t5_rst_clr", ok);
        reset = 1'b1;
        step(1);
        check("t5_rst_cs",    32'(m_chipselect), 32'h0);
        check("t5_rst_valid", 32'(evt_valid),    32'h0);
        check("t5_rst_count", 32'(evt_count),    32'h0);
        reset   = 1'b0;
        exp_cnt = 0;
        step(2);

        // T6: counter wrap
        force dut.evt_count_q = 16'hFFFF;
        step(1);
        release dut.evt_count_q;
        step(1);
        check("t6_preload", 32'(evt_count), 32'hFFFF);
        in_port = 4'h7;
        expect_evt("t6_evt", '{edges: 4'h1, level: 4'h7});
        step(1);
        check("t6_wrap",  32'(evt_count), 32'h0);
        check("t6_valid", 32'(evt_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
